regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
- Integer register file for the RV32I 5-stage pipeline: 32 x XLEN registers.
- Feeds the rv1/rv2 operands that the execute-stage units (R-type ALU etc.) consume.
- Accepts the writeback result (regdata) returned from those units at the WB stage.
- Holds a pending-write scoreboard that raises a decode stall when a source register still awaits writeback.

Parameters:
XLEN, 32, data width of each register and of read/write data
NREGS, 32, number of architectural registers (x0..x31)
AW, 5, register address width, must equal clog2(NREGS)

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
rd_en  in  1  ID-stage operand read request; updates rv1/rv2 when high
rs1_addr  in  AW  source register 1 index
rs2_addr  in  AW  source register 2 index
rv1  out  XLEN  registered operand 1 to ID/EX
rv2  out  XLEN  registered operand 2 to ID/EX
issue_en  in  1  instruction with destination leaves ID (mark rd pending)
issue_rd  in  AW  destination register of issued instruction
wb_en  in  1  writeback valid
wb_addr  in  AW  writeback destination index
wb_data  in  XLEN  writeback result (e.g. regdata_R)
stall  out  1  combinational: a requested source is pending and not written this cycle
busy  out  NREGS  scoreboard bit vector, bit i = register i pending (debug/verify)

Behaviour:
- Reset, synchronous, active-high, dominates all other inputs in that cycle:
  - all registers 0
  - busy = 0
  - rv1 = rv2 = 0
  - pending write/issue in the reset cycle is discarded
- x0:
  - Reads of x0 always return 0.
  - wb_en to x0 is ignored.
  - issue_en to x0 never sets busy[0].
  - stall never asserted due to x0.
- Write:
  - On clk edge with wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data.
  - Same edge clears busy[wb_addr], unless the set rule below applies.
- Read latency is 1 cycle:
  - With rd_en=1 at edge N, rv1/rv2 hold the operands from edge N onward.
  - With rd_en=0, rv1/rv2 hold their previous values.
- Write-first bypass: if wb_en=1 and wb_addr==rsX_addr (nonzero) in the same cycle as rd_en=1, rvX captures wb_data, not the stale array value.
  - Both ports bypass independently.
  - rs1_addr==rs2_addr is legal, and both ports get the same value.
- Scoreboard:
  - issue_en=1, issue_rd!=0: busy[issue_rd] <= 1.
  - wb_en=1, wb_addr!=0: busy[wb_addr] <= 0.
  - Same register set and cleared in the same cycle: set wins (newer instruction owns the register).
  - Different registers set and cleared in the same cycle: both take effect.
- Stall (combinational): stall = rd_en & ((busy[rs1_addr] & rs1_addr!=0 & !(wb_en & wb_addr==rs1_addr)) | same term for rs2).
  - A register being written this cycle does not stall, because the bypass supplies its value.
- While stall=1, rv1/rv2 still update per rd_en. Upstream must hold and re-present the read; the block does not gate its own capture.
- Stall and scoreboard are independent: issue_en is honoured even while stall=1. Upstream must not assert issue_en while stalled.
- No ordering checks: wb to a non-busy register is legal and simply writes.

Test Plan:
- Reset clears state: write x5=0xDEADBEEF, then assert reset 1 cycle, then read x5 -> rv1=0x00000000, busy=0, stall=0.
- x0 stays zero: wb_en x0=0xFFFFFFFF, next cycle read rs1=x0, rs2=x0 -> rv1=rv2=0. issue_rd=0 -> busy[0] stays 0.
- Write-first bypass: x7=0x11; in one cycle wb x7=0x22 with rd_en rs1=x7, rs2=x7 -> next cycle rv1=rv2=0x22.
- Scoreboard stall:
  - issue_en rd=x3, then rd_en rs2=x3 with wb_en=0 -> stall=1.
  - Next cycle wb x3=0x1234 with the same read -> stall=0, rv2=0x1234 after edge, busy[3]=0.
- Set-wins collision: busy[9]=1; same cycle issue_en rd=x9 and wb_en x9=0x5 -> busy[9]=1, reg x9=0x5.
- Hold and mid-op reset:
  - rd_en=0 for 3 cycles while x1 is rewritten -> rv1 unchanged.
  - Then reset with issue_en and wb_en high -> all registers 0, busy=0, rv1=0.

Source files
------------

// File: rtl/regfile_wb.sv
// regfile_wb: RV32I integer register file with write-first bypass and a
// pending-write scoreboard that drives the decode-stage stall.
//
// Ports:
//   clk, reset          - core clock; synchronous active-high reset
//   rd_en               - ID operand read request; captures rv1/rv2 when high
//   rs1_addr, rs2_addr  - source register indices
//   rv1, rv2            - registered operands to ID/EX (1-cycle read latency)
//   issue_en, issue_rd  - instruction with destination leaves ID; mark rd pending
//   wb_en, wb_addr,
//   wb_data             - writeback from the WB stage
//   stall               - combinational: a requested source is still pending
//   busy                - scoreboard vector, bit i set while x[i] awaits writeback
module regfile_wb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rv1,
    output logic [XLEN-1:0]  rv2,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             stall,
    output logic [NREGS-1:0] busy
);

    // Architectural state; entry 0 is never written so it reads as zero.
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  rv1_q, rv1_d;
    logic [XLEN-1:0]  rv2_q, rv2_d;
    logic [NREGS-1:0] busy_q, busy_d;

    // Qualified write / issue strobes (x0 is never a real destination).
    logic wb_valid;
    logic issue_valid;
    logic rs1_wb_hit;
    logic rs2_wb_hit;
    logic [XLEN-1:0] rd1_val;
    logic [XLEN-1:0] rd2_val;

    assign wb_valid    = wb_en && (wb_addr != '0);
    assign issue_valid = issue_en && (issue_rd != '0);
    assign rs1_wb_hit  = wb_valid && (wb_addr == rs1_addr);
    assign rs2_wb_hit  = wb_valid && (wb_addr == rs2_addr);

    // Operand read with write-first bypass; x0 forced to zero.
    always_comb begin
        rd1_val = '0;
        rd2_val = '0;
        if (rs1_addr != '0) begin
            rd1_val = rs1_wb_hit ? wb_data : regs_q[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rd2_val = rs2_wb_hit ? wb_data : regs_q[rs2_addr];
        end
    end

    // Operand capture: hold unless a read is requested.
    always_comb begin
        rv1_d = rv1_q;
        rv2_d = rv2_q;
        if (rd_en) begin
            rv1_d = rd1_val;
            rv2_d = rd2_val;
        end
    end

    // Scoreboard: clear on writeback, then set on issue so a newer owner wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Stall only on a pending source that is not being written this cycle;
    // a same-cycle writeback is covered by the bypass.
    always_comb begin
        stall = 1'b0;
        if (rd_en) begin
            if ((rs1_addr != '0) && busy_q[rs1_addr] && !rs1_wb_hit) begin
                stall = 1'b1;
            end
            if ((rs2_addr != '0) && busy_q[rs2_addr] && !rs2_wb_hit) begin
                stall = 1'b1;
            end
        end
    end

    // Register array; reset dominates any same-cycle writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_valid) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Operand and scoreboard registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rv1_q  <= '0;
            rv2_q  <= '0;
            busy_q <= '0;
        end else begin
            rv1_q  <= rv1_d;
            rv2_q  <= rv2_d;
            busy_q <= busy_d;
        end
    end

    assign rv1  = rv1_q;
    assign rv2  = rv2_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus a randomized
// run, all checked against an array/bit-vector model of the register file.
module tb_regfile_wb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    logic             clk;
    logic             reset;
    logic             rd_en;
    logic [AW-1:0]    rs1_addr;
    logic [AW-1:0]    rs2_addr;
    logic [XLEN-1:0]  rv1;
    logic [XLEN-1:0]  rv2;
    logic             issue_en;
    logic [AW-1:0]    issue_rd;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic             stall;
    logic [NREGS-1:0] busy;

    int total;
    int bad;

    // Reference model state.
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    logic [XLEN-1:0]  m_rv1;
    logic [XLEN-1:0]  m_rv2;

    regfile_wb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rv1      (rv1),
        .rv2      (rv2),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .stall    (stall),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        reset    = 1'b0;
        rd_en    = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        issue_en = 1'b0;
        issue_rd = '0;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
    endtask

    // Value an architectural read of register a returns this cycle.
    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic m_pending(input logic [AW-1:0] a);
        return (a != 0) && m_busy[a] && !(wb_en && wb_addr == a);
    endfunction

    function automatic logic m_stall();
        return rd_en && (m_pending(rs1_addr) || m_pending(rs2_addr));
    endfunction

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic tick();
        logic [XLEN-1:0] n1;
        logic [XLEN-1:0] n2;
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) m_regs[i] = '0;
            m_busy = '0;
            m_rv1  = '0;
            m_rv2  = '0;
        end else begin
            n1 = m_read(rs1_addr);
            n2 = m_read(rs2_addr);
            if (rd_en) begin
                m_rv1 = n1;
                m_rv2 = n2;
            end
            if (wb_en && wb_addr != 0) begin
                m_regs[wb_addr] = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        idle();
        total++;
        if (rv1 !== 32'h0 || rv2 !== 32'h0) begin
            bad++;
            $display("FAIL reset_rv: rv1=%h rv2=%h required 0/0", rv1, rv2);
        end
        total++;
        if (busy !== '0) begin
            bad++;
            $display("FAIL reset_busy: busy=%h required 0", busy);
        end
        // write x5, reset, read x5
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        idle();
        reset = 1'b1;
        tick();
        idle();
        rd_en = 1'b1; rs1_addr = 5'd5;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall: stall=%b required 0", stall);
        end
        tick();
        idle();
        total++;
        if (rv1 !== 32'h0) begin
            bad++;
            $display("FAIL reset_x5: rv1=%h required 00000000", rv1);
        end
        total++;
        if (busy !== '0) begin
            bad++;
            $display("FAIL reset_x5_busy: busy=%h required 0", busy);
        end
    endtask

    task automatic test_x0();
        idle();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_rd = 5'd0;
        rd_en = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        idle();
        rd_en = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL x0_stall: stall=%b required 0", stall);
        end
        tick();
        idle();
        total++;
        if (rv1 !== 32'h0 || rv2 !== 32'h0) begin
            bad++;
            $display("FAIL x0_read: rv1=%h rv2=%h required 0/0", rv1, rv2);
        end
        total++;
        if (busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL x0_busy: busy[0]=%b required 0", busy[0]);
        end
    endtask

    task automatic test_bypass();
        idle();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h11;
        tick();
        idle();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
        rd_en = 1'b1; rs1_addr = 5'd7; rs2_addr = 5'd7;
        tick();
        idle();
        total++;
        if (rv1 !== 32'h22 || rv2 !== 32'h22) begin
            bad++;
            $display("FAIL bypass_same: rv1=%h rv2=%h required 22/22", rv1, rv2);
        end
        // independent bypass: only rs2 matches the writeback
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h88;
        rd_en = 1'b1; rs1_addr = 5'd7; rs2_addr = 5'd8;
        tick();
        idle();
        total++;
        if (rv1 !== 32'h22 || rv2 !== 32'h88) begin
            bad++;
            $display("FAIL bypass_indep: rv1=%h rv2=%h required 22/88", rv1, rv2);
        end
    endtask

    task automatic test_stall();
        idle();
        issue_en = 1'b1; issue_rd = 5'd3;
        tick();
        idle();
        total++;
        if (busy[3] !== 1'b1) begin
            bad++;
            $display("FAIL stall_busy_set: busy[3]=%b required 1", busy[3]);
        end
        rd_en = 1'b1; rs2_addr = 5'd3;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL stall_pending: stall=%b required 1", stall);
        end
        tick();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL stall_wb_release: stall=%b required 0", stall);
        end
        tick();
        idle();
        total++;
        if (rv2 !== 32'h1234 || busy[3] !== 1'b0) begin
            bad++;
            $display("FAIL stall_wb_value: rv2=%h busy[3]=%b required 00001234/0", rv2, busy[3]);
        end
    endtask

    task automatic test_set_wins();
        idle();
        issue_en = 1'b1; issue_rd = 5'd9;
        tick();
        idle();
        issue_en = 1'b1; issue_rd = 5'd9;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h5;
        tick();
        idle();
        total++;
        if (busy[9] !== 1'b1) begin
            bad++;
            $display("FAIL set_wins_busy: busy[9]=%b required 1", busy[9]);
        end
        // different registers set and cleared together
        issue_en = 1'b1; issue_rd = 5'd10;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h6;
        tick();
        idle();
        total++;
        if (busy[9] !== 1'b0 || busy[10] !== 1'b1) begin
            bad++;
            $display("FAIL set_clear_diff: busy[9]=%b busy[10]=%b required 0/1", busy[9], busy[10]);
        end
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h0;
        tick();
        idle();
        rd_en = 1'b1; rs1_addr = 5'd9;
        tick();
        idle();
        total++;
        if (rv1 !== 32'h6) begin
            bad++;
            $display("FAIL set_wins_data: rv1=%h required 00000006", rv1);
        end
    endtask

    task automatic test_hold_reset();
        idle();
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hAAAA5555;
        tick();
        idle();
        rd_en = 1'b1; rs1_addr = 5'd1;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h100 + 32'(k);
            rs1_addr = 5'd1;
            tick();
            idle();
            total++;
            if (rv1 !== 32'hAAAA5555) begin
                bad++;
                $display("FAIL hold_rv1: cycle=%0d rv1=%h required aaaa5555", k, rv1);
            end
        end
        issue_en = 1'b1; issue_rd = 5'd4;
        tick();
        idle();
        reset = 1'b1; issue_en = 1'b1; issue_rd = 5'd6;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hCAFEF00D;
        rd_en = 1'b1; rs1_addr = 5'd1;
        tick();
        idle();
        total++;
        if (rv1 !== 32'h0 || busy !== '0) begin
            bad++;
            $display("FAIL midop_reset: rv1=%h busy=%h required 0/0", rv1, busy);
        end
        for (int r = 1; r < 4; r++) begin
            rd_en = 1'b1; rs1_addr = AW'(r); rs2_addr = AW'(r + 4);
            tick();
            idle();
            total++;
            if (rv1 !== 32'h0 || rv2 !== 32'h0) begin
                bad++;
                $display("FAIL midop_regs: x%0d=%h x%0d=%h required 0/0", r, rv1, r + 4, rv2);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 49) == 0);
            rd_en    = ($urandom_range(0, 3) != 0);
            rs1_addr = AW'($urandom_range(0, 7));
            rs2_addr = AW'($urandom_range(0, 7));
            issue_en = ($urandom_range(0, 2) == 0);
            issue_rd = AW'($urandom_range(0, 7));
            wb_en    = ($urandom_range(0, 1) == 0);
            wb_addr  = AW'($urandom_range(0, 7));
            wb_data  = $urandom;
            #1;
            total++;
            if (stall !== m_stall()) begin
                bad++;
                $display("FAIL rnd_stall: step=%0d stall=%b required %b", n, stall, m_stall());
            end
            tick();
            total++;
            if (rv1 !== m_rv1 || rv2 !== m_rv2 || busy !== m_busy) begin
                bad++;
                $display("FAIL rnd_state: step=%0d rv1=%h rv2=%h busy=%h required %h %h %h",
                         n, rv1, rv2, busy, m_rv1, m_rv2, m_busy);
            end
        end
        idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < int'(NREGS); i++) m_regs[i] = '0;
        m_busy = '0;
        m_rv1  = '0;
        m_rv2  = '0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_x0();
        test_bypass();
        test_stall();
        test_set_wins();
        test_hold_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
